pipe_reg_arst: RTL and testbench

- Parametrised multi-stage register pipeline with a valid/ready handshake on each stage.
- Generalises the plain async-reset D register in width, depth and reset value.
- Adds backpressure, bubble collapsing, a synchronous flush and an occupancy count.
- Used as a generic retiming/delay slice between datapath blocks.

---
 rtl/pipe_pkg.sv | 9 +
 rtl/pipe_stage.sv | 50 +++++
 rtl/pipe_reg_arst.sv | 86 ++++++++
 tb/tb_pipe_reg_arst.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared helpers for the register pipeline slice.
// Holds the occupancy-width calculation used by the top.
package pipe_pkg;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a valid/data register pair plus its ready term.
// The data register only loads on an accepted valid word.
module pipe_stage #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             rdy
);

  logic             v_q;
  logic             v_d;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] d_d;

  assign rdy = !v_q | dn_ready;
  assign v   = v_q;
  assign d   = d_q;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (rdy) begin
      v_d = up_valid;
      if (up_valid) begin
        d_d = up_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= 1'b0;
      d_q <= RST_VAL;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

endmodule

// File: rtl/pipe_reg_arst.sv
// Multi-stage valid/ready register pipeline with bubble collapsing,
// synchronous flush and a registered occupancy count.
module pipe_reg_arst
  import pipe_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [occ_w(DEPTH)-1:0]      occupancy
);

  localparam int OW = occ_w(DEPTH);

  logic             v    [DEPTH];
  logic             rdy  [DEPTH];
  logic             up_v [DEPTH];
  logic             dn_r [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [WIDTH-1:0] d    [DEPTH];

  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    if (i == 0) begin : g_head
      assign up_v[i] = in_valid;
      assign up_d[i] = in_data;
    end else begin : g_body
      assign up_v[i] = v[i-1];
      assign up_d[i] = d[i-1];
    end
    if (i == DEPTH - 1) begin : g_tail
      assign dn_r[i] = out_ready;
    end else begin : g_mid
      assign dn_r[i] = rdy[i+1];
    end
    pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (up_v[i]),
      .up_data  (up_d[i]),
      .dn_ready (dn_r[i]),
      .v        (v[i]),
      .d        (d[i]),
      .rdy      (rdy[i])
    );
  end

  assign in_ready  = rdy[0] & !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign occupancy = occ_q;

  // Count the valid bits each stage will hold after this edge
  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!flush && (rdy[i] ? up_v[i] : v[i])) begin
        occ_d = occ_d + OW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_arst.sv
// Randomised and directed bench for pipe_reg_arst against a
// word-position queue model of the pipeline.
module tb_pipe_reg_arst;

  localparam int         W  = 8;
  localparam int         D  = 4;
  localparam logic [7:0] RV = 8'h00;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [2:0]   occupancy;

  pipe_reg_arst #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // model: each in-flight word with its stage position, oldest first
  logic [7:0] qd [$];
  int         qp [$];
  logic [7:0] last_out = RV;
  int         occ_m = 0;
  logic [7:0] got [$];
  int         gotc [$];
  int         cyc = 0;
  bit         acc = 0;
  int         nvec = 0;
  int         nerr = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_ov();
    return qp.size() > 0 && qp[0] == D - 1;
  endfunction

  function automatic bit m_ir();
    return !flush && (qd.size() < D || out_ready);
  endfunction

  task automatic m_reset();
    qd.delete();
    qp.delete();
    last_out = RV;
    occ_m = 0;
  endtask

  task automatic check();
    cmp("out_valid", int'(out_valid), int'(m_ov()));
    cmp("out_data", int'(out_data), int'(last_out));
    cmp("in_ready", int'(in_ready), int'(m_ir()));
    cmp("occupancy", int'(occupancy), occ_m);
  endtask

  task automatic model_edge();
    bit         ir;
    bit         fire;
    int         lim;
    int         p;
    int         n;
    logic [7:0] nd [$];
    int         np [$];
    ir   = m_ir();
    fire = m_ov() && out_ready;
    acc  = 0;
    cyc++;
    if (fire) begin
      got.push_back(qd[0]);
      gotc.push_back(cyc);
    end
    if (flush) begin
      qd.delete();
      qp.delete();
    end else begin
      lim = D;
      for (int k = 0; k < qd.size(); k++) begin
        p = qp[k];
        if (k == 0 && fire) continue;
        if (p == D - 1) n = p;
        else n = (p + 1 < lim) ? p + 1 : lim - 1;
        if (n == D - 1 && p != D - 1) last_out = qd[k];
        lim = n;
        nd.push_back(qd[k]);
        np.push_back(n);
      end
      acc = in_valid && ir;
      if (acc) begin
        if (lim == 0) begin
          nerr++;
          $display("FAIL model_overrun: stage 0 still %0d expected empty", lim);
        end
        nd.push_back(in_data);
        np.push_back(0);
      end
      qd = nd;
      qp = np;
    end
    occ_m = qd.size();
  endtask

  task automatic cycle(input bit iv, input logic [7:0] id,
                       input bit ordy, input bit fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    check();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic areset();
    rst = 1'b0;
    #1;
    m_reset();
    check();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int idx;
    #12;
    check();
    @(posedge clk);
    #1;
    rst = 1'b1;
    cmp("rst_out_valid", int'(out_valid), 0);
    cmp("rst_out_data", int'(out_data), 8'h00);
    cmp("rst_occupancy", int'(occupancy), 0);

    // streaming
    got.delete(); gotc.delete();
    for (int i = 0; i < 8; i++) begin
      cycle(1, 8'(i + 1), 1, 0);
      if (i == 3) begin
        cmp("lat_valid", int'(out_valid), 1);
        cmp("lat_data", int'(out_data), 8'h01);
      end
      if (i == 5) cmp("stream_occ", int'(occupancy), 4);
    end
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0);
    cmp("stream_cnt", got.size(), 8);
    for (int k = 0; k < got.size(); k++) begin
      cmp("stream_word", int'(got[k]), k + 1);
      cmp("stream_gap", gotc[k] - gotc[0], k);
    end

    // backpressure and fill
    got.delete(); gotc.delete();
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1, 8'(8'hA0 + idx), 0, 0);
      if (acc) idx++;
    end
    cmp("fill_accepts", idx, 4);
    cmp("fill_in_ready", int'(in_ready), 0);
    cmp("fill_occ", int'(occupancy), 4);
    for (int c = 0; c < 20; c++) begin
      if (idx < 6) begin
        cycle(1, 8'(8'hA0 + idx), 1, 0);
        if (acc) idx++;
      end else begin
        cycle(0, 8'h00, 1, 0);
      end
    end
    cmp("bp_cnt", got.size(), 6);
    for (int k = 0; k < got.size(); k++)
      cmp("bp_word", int'(got[k]), 8'hA0 + k);

    // bubble collapse
    got.delete(); gotc.delete();
    cycle(1, 8'h11, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h22, 0, 0);
    for (int c = 0; c < 4; c++) cycle(0, 8'h00, 0, 0);
    cmp("bub_occ", int'(occupancy), 2);
    cmp("bub_valid", int'(out_valid), 1);
    cmp("bub_data", int'(out_data), 8'h11);
    for (int c = 0; c < 6; c++) cycle(0, 8'h00, 1, 0);
    cmp("bub_cnt", got.size(), 2);
    if (got.size() == 2) begin
      cmp("bub_w0", int'(got[0]), 8'h11);
      cmp("bub_w1", int'(got[1]), 8'h22);
      cmp("bub_gap", gotc[1] - gotc[0], 1);
    end

    // flush
    got.delete(); gotc.delete();
    for (int k = 0; k < 3; k++) cycle(1, 8'(8'h31 + k), 0, 0);
    cmp("fl_pre_occ", int'(occupancy), 3);
    cycle(1, 8'hFF, 0, 1);
    cmp("fl_occ", int'(occupancy), 0);
    cmp("fl_valid", int'(out_valid), 0);
    cmp("fl_data", int'(out_data), 8'h22);
    for (int c = 0; c < 6; c++) cycle(0, 8'h00, 1, 0);
    cmp("fl_nothing_out", got.size(), 0);

    // full pop and push together
    got.delete(); gotc.delete();
    for (int k = 0; k < 4; k++) cycle(1, 8'(8'h41 + k), 0, 0);
    cmp("pp_full_ready", int'(in_ready), 0);
    cmp("pp_full_occ", int'(occupancy), 4);
    cycle(1, 8'h55, 1, 0);
    cmp("pp_occ", int'(occupancy), 4);
    cmp("pp_data", int'(out_data), 8'h42);
    for (int c = 0; c < 8; c++) cycle(0, 8'h00, 1, 0);
    cmp("pp_cnt", got.size(), 5);
    for (int k = 0; k < got.size(); k++)
      cmp("pp_word", int'(got[k]), (k < 4) ? 8'h41 + k : 8'h55);

    // asynchronous reset while words are in flight
    cycle(1, 8'h61, 0, 0);
    cycle(1, 8'h62, 0, 0);
    rst = 1'b0;
    #1;
    cmp("ar_valid", int'(out_valid), 0);
    cmp("ar_occ", int'(occupancy), 0);
    cmp("ar_data", int'(out_data), 8'h00);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        areset();
      end else begin
        cycle(1'($urandom_range(0, 2) != 0), 8'($urandom),
              1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 19) == 0));
      end
    end
    cycle(0, 8'h00, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
